// File: rtl/descrambler_serialout_demux_if.sv
// Handshake and data bundle between the serial receive path and the lane descrambler.
// The slave side is the descrambler. The master side is whatever feeds and drains it.
interface descrambler_serialout_demux_if;
   localparam int unsigned IN_W   = 16;
   localparam int unsigned LANE_W = 32;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   logic [4:0]        slot;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_lane;
   logic [LANE_W-1:0] out_data;
   logic              frame_done;

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, slot, out_valid, out_lane, out_data, frame_done
   );

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, slot, out_valid, out_lane, out_data, frame_done
   );
endinterface

// File: rtl/descrambler_serialout_demux.sv
// Steers each bit of 32 scrambled slot words back to its source lane, rebuilding 16 lane words.
// The lane words are then drained one per cycle over valid/ready.
module descrambler_serialout_demux (
   input  logic                         clk,
   input  logic                         rst,
   descrambler_serialout_demux_if.slave bus
);
   localparam int unsigned NLANES = 16;
   localparam int unsigned NSLOTS = 32;
   localparam int unsigned IN_W   = 16;
   localparam int unsigned LANE_W = 32;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;

   state_e                         state_q, state_d;
   logic [4:0]                     slot_q, slot_d;
   logic [3:0]                     lane_idx_q, lane_idx_d;
   logic                           frame_done_q, frame_done_d;
   logic [NLANES-1:0][LANE_W-1:0]  lane_q, lane_d;
   logic [3:0]                     dst;

   // Next-state logic. Flush beats any handshake in the same cycle.
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      lane_idx_d   = lane_idx_q;
      frame_done_d = 1'b0;
      lane_d       = lane_q;
      dst          = '0;
      if (bus.flush) begin
         state_d    = FILL;
         slot_d     = '0;
         lane_idx_d = '0;
      end else if (state_q == FILL) begin
         if (bus.in_valid) begin
            // Bit b of slot s belongs to lane (5*b + s) mod 16.
            for (int b = 0; b < int'(IN_W); b++) begin
               dst = 4'(5 * b + int'(slot_q));
               lane_d[dst][slot_q] = bus.in_data[b];
            end
            slot_d = slot_q + 5'd1;
            if (slot_q == 5'(NSLOTS - 1)) begin
               state_d    = DRAIN;
               lane_idx_d = '0;
            end
         end
      end else if (bus.out_ready) begin
         lane_idx_d = lane_idx_q + 4'd1;
         if (lane_idx_q == 4'(NLANES - 1)) begin
            state_d      = FILL;
            frame_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FILL;
         slot_q       <= '0;
         lane_idx_q   <= '0;
         frame_done_q <= 1'b0;
         lane_q       <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         lane_idx_q   <= lane_idx_d;
         frame_done_q <= frame_done_d;
         lane_q       <= lane_d;
      end
   end

   // Outputs decode registered state only. Reset holds off input acceptance while asserted.
   assign bus.in_ready   = (state_q == FILL) && !rst;
   assign bus.out_valid  = (state_q == DRAIN);
   assign bus.slot       = slot_q;
   assign bus.out_lane   = lane_idx_q;
   assign bus.out_data   = lane_q[lane_idx_q];
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_descrambler_serialout_demux.sv
// Self-checking bench for descrambler_serialout_demux.
// A per-cycle compare against a behavioural frame model, plus literal lane expectations.
module tb_descrambler_serialout_demux;
   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   descrambler_serialout_demux_if bus ();

   descrambler_serialout_demux dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: lane L, bit s holds the slot-s bit whose index b solves 5*b + s = L (mod 16).
   // 13 is the inverse of 5 mod 16, so b = 13*(L - s) mod 16.
   logic        m_fill;
   logic [4:0]  m_slot;
   logic [3:0]  m_idx;
   logic        m_done;
   logic [31:0] m_lanes [16];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_fill  <= 1'b1;
         m_slot  <= '0;
         m_idx   <= '0;
         m_done  <= 1'b0;
         m_lanes <= '{default: 32'h0};
      end else begin
         m_done <= 1'b0;
         if (bus.flush) begin
            m_fill <= 1'b1;
            m_slot <= '0;
            m_idx  <= '0;
         end else if (m_fill) begin
            if (bus.in_valid) begin
               for (int l = 0; l < 16; l++)
                  m_lanes[l][m_slot] <= bus.in_data[(13 * (l - int'(m_slot))) & 15];
               m_slot <= 5'((int'(m_slot) + 1) % 32);
               if (m_slot == 5'd31) begin
                  m_fill <= 1'b0;
                  m_idx  <= '0;
               end
            end
         end else if (bus.out_ready) begin
            if (m_idx == 4'd15) begin
               m_fill <= 1'b1;
               m_idx  <= '0;
               m_done <= 1'b1;
            end else begin
               m_idx <= 4'(int'(m_idx) + 1);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready",   32'(bus.in_ready),   32'(m_fill));
         chk("out_valid",  32'(bus.out_valid),  32'(!m_fill));
         chk("slot",       32'(bus.slot),       32'(m_slot));
         chk("out_lane",   32'(bus.out_lane),   32'(m_idx));
         chk("out_data",   bus.out_data,        m_lanes[m_idx]);
         chk("frame_done", 32'(bus.frame_done), 32'(m_done));
      end
   end

   logic [15:0] frame_w [32];
   logic [31:0] cap [16];

   // Drive one cycle of inputs and capture any lane that is accepted on the coming edge.
   task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      bus.flush     = fl;
      if (bus.out_valid && ordy && !fl) cap[bus.out_lane] = bus.out_data;
      @(negedge clk);
   endtask

   task automatic fill_frame();
      for (int s = 0; s < 32; s++) cyc(1'b1, frame_w[s], 1'b0, 1'b0);
   endtask

   task automatic drain_all();
      int n = 0;
      while (bus.out_valid && n < 40) begin
         cyc(1'b0, 16'h0, 1'b1, 1'b0);
         n++;
      end
      chk("drain_ends",      32'(bus.out_valid),  32'h0);
      chk("drain_frame_done", 32'(bus.frame_done), 32'h1);
   endtask

   task automatic drain_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
   endtask

   logic [31:0] held;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hFFFF;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      #12;
      chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_slot",      32'(bus.slot),      32'h0);
      chk("rst_out_data",  bus.out_data,       32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rel_in_ready", 32'(bus.in_ready), 32'h1);
      cyc(1'b0, 16'h0, 1'b0, 1'b0);

      // All-ones frame.
      for (int s = 0; s < 32; s++) frame_w[s] = 16'hFFFF;
      fill_frame();
      drain_all();
      for (int l = 0; l < 16; l++) chk("ones_lane", cap[l], 32'hFFFF_FFFF);

      // Permutation: slot0 bit0 -> lane0 bit0, slot1 bit1 -> lane6 bit1.
      for (int s = 0; s < 32; s++) frame_w[s] = 16'h0;
      frame_w[0] = 16'h0001;
      frame_w[1] = 16'h0002;
      fill_frame();
      drain_all();
      chk("perm_lane0", cap[0], 32'h0000_0001);
      chk("perm_lane6", cap[6], 32'h0000_0002);
      chk("perm_lane1", cap[1], 32'h0000_0000);
      chk("perm_lane3", cap[3], 32'h0000_0000);
      for (int s = 0; s < 32; s++) frame_w[s] = 16'h0;
      frame_w[31] = 16'h8000;
      fill_frame();
      drain_all();
      chk("perm_lane10", cap[10], 32'h8000_0000);
      chk("perm_lane0b", cap[0],  32'h0000_0000);

      // Back-pressure at lane 3 with ignored input pulses.
      for (int s = 0; s < 32; s++) frame_w[s] = 16'($urandom);
      fill_frame();
      drain_n(3);
      held = bus.out_data;
      for (int i = 0; i < 10; i++) cyc(1'(i & 1), 16'($urandom), 1'b0, 1'b0);
      chk("bp_lane", 32'(bus.out_lane), 32'd3);
      chk("bp_data", bus.out_data,      held);
      chk("bp_slot", 32'(bus.slot),     32'd0);
      drain_all();

      // Flush during fill, coincident with a word.
      for (int s = 0; s < 20; s++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
      chk("pre_flush_slot", 32'(bus.slot), 32'd20);
      cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
      chk("flush_slot",  32'(bus.slot),     32'd0);
      chk("flush_ready", 32'(bus.in_ready), 32'h1);

      // Flush during drain at lane 7.
      for (int s = 0; s < 32; s++) frame_w[s] = 16'($urandom);
      fill_frame();
      drain_n(7);
      chk("pre_flush_lane", 32'(bus.out_lane), 32'd7);
      cyc(1'b0, 16'h0, 1'b1, 1'b1);
      chk("dflush_valid", 32'(bus.out_valid),  32'h0);
      chk("dflush_done",  32'(bus.frame_done), 32'h0);
      chk("dflush_lane",  32'(bus.out_lane),   32'h0);

      // Asynchronous reset mid-drain at lane 9.
      for (int s = 0; s < 32; s++) frame_w[s] = 16'h1234;
      fill_frame();
      drain_n(9);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_ready", 32'(bus.in_ready),  32'h0);
      chk("arst_data",  bus.out_data,       32'h0);
      @(negedge clk);
      #1 rst = 1'b0;
      for (int s = 0; s < 32; s++) frame_w[s] = 16'hFFFF;
      fill_frame();
      drain_all();
      for (int l = 0; l < 16; l++) chk("arst_ones_lane", cap[l], 32'hFFFF_FFFF);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++)
         cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));

      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
